// File: rtl/id_exe_reg_pkg.sv
// Shared definitions for the ID/EXE pipeline register: control-word bit
// positions, execute command encodings, field widths and the captured bundle.
package id_exe_reg_pkg;

  localparam int CTRL_W   = 9;
  localparam int REG_W    = 32;
  localparam int IDX_W    = 4;
  localparam int SHIFT_W  = 12;
  localparam int IMM24_W  = 24;
  localparam int STATUS_W = 4;
  localparam int MASK_W   = 2;

  // Control word layout: {exe_cmd[3:0], mem_r_en, mem_w_en, wb_en, b, s}
  localparam int CTRL_S       = 0;
  localparam int CTRL_B       = 1;
  localparam int CTRL_WB_EN   = 2;
  localparam int CTRL_MEM_W   = 3;
  localparam int CTRL_MEM_R   = 4;
  localparam int CTRL_CMD_LSB = 5;
  localparam int CTRL_CMD_MSB = 8;

  // rd_mask bit meaning
  localparam int MASK_SRC1 = 0;
  localparam int MASK_SRC2 = 1;

  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  // A killed or bubbled slot carries no side-effect enables at all.
  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

  typedef struct packed {
    logic                valid;
    logic [CTRL_W-1:0]   ctrl;
    logic [REG_W-1:0]    pc;
    logic [REG_W-1:0]    val_rn;
    logic [REG_W-1:0]    val_rm;
    logic                imm;
    logic [SHIFT_W-1:0]  shift_operand;
    logic [IMM24_W-1:0]  signed_imm_24;
    logic [IDX_W-1:0]    dest;
    logic [IDX_W-1:0]    src1;
    logic [IDX_W-1:0]    src2;
    logic [STATUS_W-1:0] status;
    logic [MASK_W-1:0]   rd_mask;
  } exe_fields_t;

endpackage

// File: rtl/id_exe_reg_operand_refresh.sv
// Selects the next value of one held operand: a writeback that targets the
// operand's source register replaces the stale value while the stage is held.
module id_exe_reg_operand_refresh
  import id_exe_reg_pkg::*;
(
  input  logic             refresh_en,
  input  logic             wb_wb_en,
  input  logic [IDX_W-1:0] wb_dest,
  input  logic [REG_W-1:0] wb_value,
  input  logic [IDX_W-1:0] src,
  input  logic             rd_en,
  input  logic [REG_W-1:0] cur_val,
  output logic [REG_W-1:0] next_val
);

  // Take the writeback value only for a register this instruction actually reads.
  always_comb begin
    next_val = cur_val;
    if (refresh_en && wb_wb_en && rd_en && (wb_dest == src)) begin
      next_val = wb_value;
    end
  end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register. Per edge: flush > stall > bubble > load.
// Stall holds the instruction but refreshes operands from writeback; a
// saturating counter records cycles spent stalled with a valid instruction.
module id_exe_reg
  import id_exe_reg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                bubble,
  input  logic                wb_wb_en,
  input  logic [IDX_W-1:0]    wb_dest,
  input  logic [REG_W-1:0]    wb_value,
  input  logic                id_valid,
  input  logic [CTRL_W-1:0]   id_ctrl,
  input  logic [REG_W-1:0]    id_pc,
  input  logic [REG_W-1:0]    id_val_rn,
  input  logic [REG_W-1:0]    id_val_rm,
  input  logic                id_imm,
  input  logic [SHIFT_W-1:0]  id_shift_operand,
  input  logic [IMM24_W-1:0]  id_signed_imm_24,
  input  logic [IDX_W-1:0]    id_dest,
  input  logic [IDX_W-1:0]    id_src1,
  input  logic [IDX_W-1:0]    id_src2,
  input  logic [STATUS_W-1:0] id_status,
  input  logic [MASK_W-1:0]   id_rd_mask,
  output logic                exe_valid,
  output logic [CTRL_W-1:0]   exe_ctrl,
  output logic [REG_W-1:0]    exe_pc,
  output logic [REG_W-1:0]    exe_val_rn,
  output logic [REG_W-1:0]    exe_val_rm,
  output logic                exe_imm,
  output logic [SHIFT_W-1:0]  exe_shift_operand,
  output logic [IMM24_W-1:0]  exe_signed_imm_24,
  output logic [IDX_W-1:0]    exe_dest,
  output logic [IDX_W-1:0]    exe_src1,
  output logic [IDX_W-1:0]    exe_src2,
  output logic [STATUS_W-1:0] exe_status,
  output logic [MASK_W-1:0]   exe_rd_mask,
  output logic [CNT_W-1:0]    stall_cycles
);

  exe_fields_t      fields_q, fields_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [REG_W-1:0] rn_refreshed, rm_refreshed;
  logic             refresh_en;

  // Operands are refreshed only while a real instruction is being held.
  assign refresh_en = stall && fields_q.valid;

  id_exe_reg_operand_refresh u_refresh_rn (
    .refresh_en (refresh_en),
    .wb_wb_en   (wb_wb_en),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value),
    .src        (fields_q.src1),
    .rd_en      (fields_q.rd_mask[MASK_SRC1]),
    .cur_val    (fields_q.val_rn),
    .next_val   (rn_refreshed)
  );

  id_exe_reg_operand_refresh u_refresh_rm (
    .refresh_en (refresh_en),
    .wb_wb_en   (wb_wb_en),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value),
    .src        (fields_q.src2),
    .rd_en      (fields_q.rd_mask[MASK_SRC2]),
    .cur_val    (fields_q.val_rm),
    .next_val   (rm_refreshed)
  );

  // Next-state selection in priority order flush > stall > bubble > load.
  always_comb begin
    fields_d = fields_q;
    if (flush) begin
      fields_d.valid = 1'b0;
      fields_d.ctrl  = NOP_CTRL;
    end else if (stall) begin
      fields_d.val_rn = rn_refreshed;
      fields_d.val_rm = rm_refreshed;
    end else if (bubble) begin
      fields_d.valid = 1'b0;
      fields_d.ctrl  = NOP_CTRL;
    end else begin
      fields_d.valid         = id_valid;
      // An invalid slot never carries enables, whatever ID presents.
      fields_d.ctrl          = id_valid ? id_ctrl : NOP_CTRL;
      fields_d.pc            = id_pc;
      fields_d.val_rn        = id_val_rn;
      fields_d.val_rm        = id_val_rm;
      fields_d.imm           = id_imm;
      fields_d.shift_operand = id_shift_operand;
      fields_d.signed_imm_24 = id_signed_imm_24;
      fields_d.dest          = id_dest;
      fields_d.src1          = id_src1;
      fields_d.src2          = id_src2;
      fields_d.status        = id_status;
      fields_d.rd_mask       = id_rd_mask;
    end
  end

  // Saturating count of edges spent stalled on a valid instruction.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && !flush && fields_q.valid && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fields_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      fields_q       <= fields_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign exe_valid         = fields_q.valid;
  assign exe_ctrl          = fields_q.ctrl;
  assign exe_pc            = fields_q.pc;
  assign exe_val_rn        = fields_q.val_rn;
  assign exe_val_rm        = fields_q.val_rm;
  assign exe_imm           = fields_q.imm;
  assign exe_shift_operand = fields_q.shift_operand;
  assign exe_signed_imm_24 = fields_q.signed_imm_24;
  assign exe_dest          = fields_q.dest;
  assign exe_src1          = fields_q.src1;
  assign exe_src2          = fields_q.src2;
  assign exe_status        = fields_q.status;
  assign exe_rd_mask       = fields_q.rd_mask;
  assign stall_cycles      = stall_cycles_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for the ID/EXE pipeline register. Inputs change 1 ns after
// each rising edge and outputs are sampled at that same point.
module tb_id_exe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, bubble;
  logic        wb_wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        id_valid;
  logic [8:0]  id_ctrl;
  logic [31:0] id_pc, id_val_rn, id_val_rm;
  logic        id_imm;
  logic [11:0] id_shift_operand;
  logic [23:0] id_signed_imm_24;
  logic [3:0]  id_dest, id_src1, id_src2, id_status;
  logic [1:0]  id_rd_mask;

  logic        exe_valid;
  logic [8:0]  exe_ctrl;
  logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
  logic        exe_imm;
  logic [11:0] exe_shift_operand;
  logic [23:0] exe_signed_imm_24;
  logic [3:0]  exe_dest, exe_src1, exe_src2, exe_status;
  logic [1:0]  exe_rd_mask;
  logic [15:0] stall_cycles;

  logic        x4_valid;
  logic [8:0]  x4_ctrl;
  logic [31:0] x4_pc, x4_val_rn, x4_val_rm;
  logic        x4_imm;
  logic [11:0] x4_shift_operand;
  logic [23:0] x4_signed_imm_24;
  logic [3:0]  x4_dest, x4_src1, x4_src2, x4_status;
  logic [1:0]  x4_rd_mask;
  logic [3:0]  x4_stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_exe_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bubble(bubble),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
    .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
    .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
    .id_status(id_status), .id_rd_mask(id_rd_mask),
    .exe_valid(exe_valid), .exe_ctrl(exe_ctrl), .exe_pc(exe_pc),
    .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm), .exe_imm(exe_imm),
    .exe_shift_operand(exe_shift_operand), .exe_signed_imm_24(exe_signed_imm_24),
    .exe_dest(exe_dest), .exe_src1(exe_src1), .exe_src2(exe_src2),
    .exe_status(exe_status), .exe_rd_mask(exe_rd_mask),
    .stall_cycles(stall_cycles)
  );

  id_exe_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bubble(bubble),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
    .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
    .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
    .id_status(id_status), .id_rd_mask(id_rd_mask),
    .exe_valid(x4_valid), .exe_ctrl(x4_ctrl), .exe_pc(x4_pc),
    .exe_val_rn(x4_val_rn), .exe_val_rm(x4_val_rm), .exe_imm(x4_imm),
    .exe_shift_operand(x4_shift_operand), .exe_signed_imm_24(x4_signed_imm_24),
    .exe_dest(x4_dest), .exe_src1(x4_src1), .exe_src2(x4_src2),
    .exe_status(x4_status), .exe_rd_mask(x4_rd_mask),
    .stall_cycles(x4_stall_cycles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_id(input logic [8:0] ctrl, input logic [31:0] pc,
                         input logic [31:0] rn, input logic [31:0] rm,
                         input logic [3:0] s1, input logic [3:0] s2,
                         input logic [1:0] mask);
    id_valid         = 1'b1;
    id_ctrl          = ctrl;
    id_pc            = pc;
    id_val_rn        = rn;
    id_val_rm        = rm;
    id_imm           = 1'b1;
    id_shift_operand = 12'hABC;
    id_signed_imm_24 = 24'h123456;
    id_dest          = 4'h9;
    id_src1          = s1;
    id_src2          = s2;
    id_status        = 4'b1010;
    id_rd_mask       = mask;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({exe_valid, exe_ctrl, exe_pc, exe_val_rn, exe_val_rm, exe_dest, exe_src1,
         exe_rd_mask, exe_shift_operand, exe_signed_imm_24, exe_status, exe_imm} !== '0) begin
      errors++; $display("FAIL reset_fields: got nonzero exe_* (pc=%h rn=%h ctrl=%h) required 0",
                         exe_pc, exe_val_rn, exe_ctrl);
    end
    checks++;
    if (stall_cycles !== 16'd0) begin
      errors++; $display("FAIL reset_stall_cycles: got %0d required 0", stall_cycles);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_load();
    load_id(9'h0A5, 32'h10, 32'd5, 32'd7, 4'd3, 4'd4, 2'b01);
    step();
    checks++;
    if (exe_pc !== 32'h10 || exe_val_rn !== 32'd5 || exe_valid !== 1'b1) begin
      errors++; $display("FAIL load_basic: got pc=%h rn=%h valid=%b required pc=10 rn=5 valid=1",
                         exe_pc, exe_val_rn, exe_valid);
    end
    checks++;
    if (exe_ctrl !== 9'h0A5 || exe_val_rm !== 32'd7 || exe_src1 !== 4'd3 ||
        exe_src2 !== 4'd4 || exe_rd_mask !== 2'b01 || exe_dest !== 4'h9 ||
        exe_status !== 4'b1010 || exe_imm !== 1'b1 || exe_shift_operand !== 12'hABC ||
        exe_signed_imm_24 !== 24'h123456) begin
      errors++; $display("FAIL load_fields: got ctrl=%h rm=%h s1=%h s2=%h mask=%b required ctrl=0a5 rm=7 s1=3 s2=4 mask=01",
                         exe_ctrl, exe_val_rm, exe_src1, exe_src2, exe_rd_mask);
    end
  endtask

  task automatic test_refresh();
    // Change ID so a hold is distinguishable from a reload.
    load_id(9'h1FF, 32'h99, 32'h11, 32'h22, 4'd7, 4'd8, 2'b11);
    stall = 1'b1; wb_wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hAA;
    step();
    checks++;
    if (exe_val_rn !== 32'hAA || exe_val_rm !== 32'd7 || exe_pc !== 32'h10 ||
        exe_ctrl !== 9'h0A5 || stall_cycles !== 16'd1) begin
      errors++; $display("FAIL refresh_src1: got rn=%h rm=%h pc=%h ctrl=%h sc=%0d required rn=aa rm=7 pc=10 ctrl=0a5 sc=1",
                         exe_val_rn, exe_val_rm, exe_pc, exe_ctrl, stall_cycles);
    end
    wb_dest = 4'd4; wb_value = 32'hBB;
    step();
    checks++;
    if (exe_val_rn !== 32'hAA || exe_val_rm !== 32'd7 || stall_cycles !== 16'd2) begin
      errors++; $display("FAIL refresh_miss: got rn=%h rm=%h sc=%0d required rn=aa rm=7 sc=2",
                         exe_val_rn, exe_val_rm, stall_cycles);
    end
    wb_wb_en = 1'b0; wb_dest = 4'd3; wb_value = 32'hCC;
    step();
    checks++;
    if (exe_val_rn !== 32'hAA || stall_cycles !== 16'd3) begin
      errors++; $display("FAIL refresh_wb_off: got rn=%h sc=%0d required rn=aa sc=3",
                         exe_val_rn, stall_cycles);
    end
    // Load edge with a matching writeback: the captured operands are not replaced.
    stall = 1'b0;
    load_id(9'h041, 32'h20, 32'd1, 32'd2, 4'd2, 4'd2, 2'b11);
    wb_wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h55;
    step();
    checks++;
    if (exe_val_rn !== 32'd1 || exe_val_rm !== 32'd2 || exe_pc !== 32'h20) begin
      errors++; $display("FAIL no_refresh_on_load: got rn=%h rm=%h pc=%h required rn=1 rm=2 pc=20",
                         exe_val_rn, exe_val_rm, exe_pc);
    end
    stall = 1'b1;
    step();
    checks++;
    if (exe_val_rn !== 32'h55 || exe_val_rm !== 32'h55 || stall_cycles !== 16'd4) begin
      errors++; $display("FAIL refresh_both: got rn=%h rm=%h sc=%0d required rn=55 rm=55 sc=4",
                         exe_val_rn, exe_val_rm, stall_cycles);
    end
  endtask

  task automatic test_stall_flush();
    stall = 1'b1; flush = 1'b1; wb_wb_en = 1'b0;
    step();
    checks++;
    if (exe_valid !== 1'b0 || exe_ctrl !== 9'h000 || stall_cycles !== 16'd4) begin
      errors++; $display("FAIL stall_flush: got valid=%b ctrl=%h sc=%0d required valid=0 ctrl=0 sc=4",
                         exe_valid, exe_ctrl, stall_cycles);
    end
    flush = 1'b0;
    step();
    checks++;
    if (exe_valid !== 1'b0 || exe_ctrl !== 9'h000 || stall_cycles !== 16'd4) begin
      errors++; $display("FAIL stall_invalid: got valid=%b ctrl=%h sc=%0d required valid=0 ctrl=0 sc=4",
                         exe_valid, exe_ctrl, stall_cycles);
    end
    stall = 1'b0;
  endtask

  task automatic test_bubble();
    load_id(9'h1FF, 32'h300, 32'd9, 32'd9, 4'd1, 4'd1, 2'b00);
    bubble = 1'b1;
    step();
    checks++;
    if (exe_valid !== 1'b0 || exe_ctrl !== 9'h000) begin
      errors++; $display("FAIL bubble: got valid=%b ctrl=%h required valid=0 ctrl=0", exe_valid, exe_ctrl);
    end
    bubble = 1'b0;
    load_id(9'h123, 32'h200, 32'd3, 32'd4, 4'd1, 4'd1, 2'b00);
    step();
    checks++;
    if (exe_valid !== 1'b1 || exe_ctrl !== 9'h123 || exe_pc !== 32'h200) begin
      errors++; $display("FAIL load_after_bubble: got valid=%b ctrl=%h pc=%h required valid=1 ctrl=123 pc=200",
                         exe_valid, exe_ctrl, exe_pc);
    end
    stall = 1'b1; bubble = 1'b1;
    load_id(9'h0FF, 32'h400, 32'd8, 32'd8, 4'd5, 4'd5, 2'b11);
    step();
    checks++;
    if (exe_valid !== 1'b1 || exe_ctrl !== 9'h123 || exe_pc !== 32'h200 ||
        exe_val_rn !== 32'd3 || stall_cycles !== 16'd5) begin
      errors++; $display("FAIL stall_bubble_hold: got valid=%b ctrl=%h pc=%h rn=%h sc=%0d required valid=1 ctrl=123 pc=200 rn=3 sc=5",
                         exe_valid, exe_ctrl, exe_pc, exe_val_rn, stall_cycles);
    end
    stall = 1'b0; bubble = 1'b0;
    id_valid = 1'b0; id_ctrl = 9'h1FF;
    step();
    checks++;
    if (exe_valid !== 1'b0 || exe_ctrl !== 9'h000) begin
      errors++; $display("FAIL invalid_ctrl_zero: got valid=%b ctrl=%h required valid=0 ctrl=0", exe_valid, exe_ctrl);
    end
  endtask

  task automatic test_async_reset();
    load_id(9'h0A5, 32'h500, 32'd6, 32'd6, 4'd1, 4'd2, 2'b11);
    step();
    stall = 1'b1;
    step();
    step();
    checks++;
    if (exe_valid !== 1'b1 || stall_cycles !== 16'd7) begin
      errors++; $display("FAIL pre_reset_state: got valid=%b sc=%0d required valid=1 sc=7", exe_valid, stall_cycles);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({exe_valid, exe_ctrl, exe_pc, exe_val_rn, exe_val_rm, exe_src1, exe_src2,
         exe_rd_mask, exe_dest} !== '0 || stall_cycles !== 16'd0 || x4_stall_cycles !== 4'd0) begin
      errors++; $display("FAIL async_reset: got valid=%b ctrl=%h pc=%h sc=%0d required all 0",
                         exe_valid, exe_ctrl, exe_pc, stall_cycles);
    end
    #2 rst = 1'b0;
    step();
    checks++;
    if (exe_valid !== 1'b0 || exe_pc !== 32'h0 || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL post_reset_stall: got valid=%b pc=%h sc=%0d required valid=0 pc=0 sc=0",
                         exe_valid, exe_pc, stall_cycles);
    end
    stall = 1'b0;
  endtask

  task automatic test_saturate();
    load_id(9'h0C4, 32'h600, 32'd1, 32'd2, 4'd1, 4'd2, 2'b00);
    step();
    stall = 1'b1;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (x4_stall_cycles !== 4'd15 || x4_valid !== 1'b1 || x4_pc !== 32'h600) begin
      errors++; $display("FAIL sat_reach: got sc4=%0d valid=%b pc=%h required sc4=15 valid=1 pc=600",
                         x4_stall_cycles, x4_valid, x4_pc);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (x4_stall_cycles !== 4'd15) begin
      errors++; $display("FAIL sat_hold: got sc4=%0d required 15", x4_stall_cycles);
    end
    checks++;
    if (stall_cycles !== 16'd20) begin
      errors++; $display("FAIL wide_count: got sc=%0d required 20", stall_cycles);
    end
    checks++;
    if (x4_ctrl !== 9'h0C4 || x4_val_rn !== 32'd1 || x4_val_rm !== 32'd2 ||
        x4_imm !== 1'b1 || x4_shift_operand !== 12'hABC || x4_signed_imm_24 !== 24'h123456 ||
        x4_dest !== 4'h9 || x4_src1 !== 4'd1 || x4_src2 !== 4'd2 ||
        x4_status !== 4'b1010 || x4_rd_mask !== 2'b00) begin
      errors++; $display("FAIL sat_fields_held: got ctrl=%h rn=%h rm=%h required ctrl=0c4 rn=1 rm=2",
                         x4_ctrl, x4_val_rn, x4_val_rm);
    end
    stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0; flush = 1'b0; bubble = 1'b0;
    wb_wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    id_valid = 1'b0; id_ctrl = '0; id_pc = '0; id_val_rn = '0; id_val_rm = '0;
    id_imm = 1'b0; id_shift_operand = '0; id_signed_imm_24 = '0;
    id_dest = '0; id_src1 = '0; id_src2 = '0; id_status = '0; id_rd_mask = '0;

    test_reset();
    test_load();
    test_refresh();
    test_stall_flush();
    test_bubble();
    test_async_reset();
    test_saturate();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 Parameter CNT_W, default 16, width of the saturating stall-cycle counter.
REQ-002 clk  in  1  pipeline clock; state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 stall  in  1  hold all captured fields (memory-side wait).
REQ-005 flush  in  1  kill the held or incoming instruction (branch taken).
REQ-006 bubble  in  1  load a NOP instead of the ID instruction (hazard).
REQ-007 wb_wb_en  in  1  writeback write enable.
REQ-008 wb_dest  in  4  writeback register index.
REQ-009 wb_value  in  32  writeback data.
REQ-010 id_valid  in  1  ID holds a real instruction.
REQ-011 id_ctrl  in  9  {exe_cmd[3:0], mem_r_en, mem_w_en, wb_en, b, s}.
REQ-012 id_pc, id_val_rn, id_val_rm  in  32 each  PC+4 and operand values.
REQ-013 id_imm  in  1;  id_shift_operand  in  12;  id_signed_imm_24  in  24.
REQ-014 id_dest, id_src1, id_src2  in  4 each;  id_status  in  4  NZCV.
REQ-015 id_rd_mask  in  2  bit0: src1 read, bit1: src2 read.
REQ-016 exe_* outputs  out  same widths as matching id_* (valid, ctrl, pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, src1, src2, status, rd_mask).
REQ-017 stall_cycles  out  CNT_W  cycles spent stalled holding a valid instruction.

Function
REQ-018 Per-edge priority SHALL be: flush > stall > bubble > load.
REQ-019 flush SHALL clear exe_valid and exe_ctrl to 0 next edge, regardless of stall; data fields don't-care.
REQ-020 stall (no flush) SHALL hold every exe_* field, except operand refresh per REQ-022.
REQ-021 bubble (no flush/stall) SHALL load exe_valid=0, exe_ctrl=0; load otherwise copies all id_* fields, exe_valid=id_valid.
REQ-022 Refresh: while stall and exe_valid, if wb_wb_en and wb_dest==exe_src1 and exe_rd_mask[0], exe_val_rn SHALL take wb_value next edge; likewise src2/bit1/exe_val_rm; both may update same edge.
REQ-023 No refresh on load edges (register file forwards by writing on falling edge); none when exe_valid=0.
REQ-024 When exe_valid=0, exe_ctrl SHALL be 0 (no side-effect enables leak).
REQ-025 stall_cycles SHALL increment each edge with stall=1, flush=0, exe_valid=1; saturate at all-ones, never wrap.
REQ-026 Latency: ID fields appear on exe_* one edge after capture; all outputs registered, no combinational id_*->exe_* path.
REQ-027 Simultaneous stall+bubble SHALL hold (bubble ignored; hazard unit re-asserts later).

Reset
REQ-028 rst SHALL immediately zero all exe_* outputs and stall_cycles, independent of clk.
REQ-029 rst mid-stall SHALL discard the held instruction; first post-reset edge follows REQ-018.

Structure
REQ-030 Shared package: ctrl bit positions, EXE_CMD encodings, NOP ctrl constant (9'b0), field widths.
REQ-031 One sub-module natural: operand_refresh (compare wb_dest against src/mask, select next Val_Rn/Val_Rm), instantiated twice.

Verification
REQ-032 rst=1 mid-run with exe_valid=1 -> all exe_* and stall_cycles = 0 before next clk edge.
REQ-033 Load id_pc=0x10, id_val_rn=5, id_valid=1 -> next edge exe_pc=0x10, exe_val_rn=5, exe_valid=1.
REQ-034 Held instr src1=3, mask=01, stall=1, wb_wb_en=1, wb_dest=3, wb_value=0xAA -> exe_val_rn=0xAA, exe_val_rm unchanged; wb_dest=4 -> no change.
REQ-035 stall=1 and flush=1 same edge -> exe_valid=0, exe_ctrl=0, stall_cycles unchanged.
REQ-036 bubble=1, id_ctrl=9'h1FF -> exe_ctrl=0, exe_valid=0; stall+bubble -> fields held.
REQ-037 CNT_W=4, 20 stall cycles with valid -> stall_cycles=15, stays 15.
